// File: rtl/antares_defs.sv
// antares_defs: shared opcodes, NOP word and instruction field positions for the Antares-R2 core
package antares_defs;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    // rt is a source only for R-type, branches and stores; elsewhere it is a destination
    function automatic logic uses_rt(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW;
    endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use detection between the held ID instruction and a load in EX
module hazard_detect
    import antares_defs::*;
(
    input  logic       id_valid,
    input  logic [5:0] opcode,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       hazard_stall
);
    assign hazard_stall = id_valid & ex_mem_read & (ex_rt != 5'd0) &
                          ((ex_rt == rs) | (uses_rt(opcode) & (ex_rt == rt)));
endmodule

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register with field split and load-use freeze
module if_id_register #(
    parameter int               DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = antares_defs::NOP_INSTR
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] if_pc_plus4,
    input  logic [DATA_WIDTH-1:0] if_instruction,
    input  logic                  if_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_mem_read,
    input  logic [4:0]            ex_rt,
    output logic [DATA_WIDTH-1:0] id_pc_plus4,
    output logic [DATA_WIDTH-1:0] id_instruction,
    output logic                  id_valid,
    output logic [5:0]            opcode,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [4:0]            shamt,
    output logic [5:0]            funct,
    output logic [15:0]           immediate,
    output logic [25:0]           jump_index,
    output logic                  hazard_stall,
    output logic                  id_bubble
);
    assign opcode     = id_instruction[antares_defs::OPCODE_LSB +: 6];
    assign rs         = id_instruction[antares_defs::RS_LSB +: 5];
    assign rt         = id_instruction[antares_defs::RT_LSB +: 5];
    assign rd         = id_instruction[antares_defs::RD_LSB +: 5];
    assign shamt      = id_instruction[antares_defs::SHAMT_LSB +: 5];
    assign funct      = id_instruction[antares_defs::FUNCT_LSB +: 6];
    assign immediate  = id_instruction[15:0];
    assign jump_index = id_instruction[25:0];

    hazard_detect u_hazard (
        .id_valid     (id_valid),
        .opcode       (opcode),
        .rs           (rs),
        .rt           (rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .hazard_stall (hazard_stall)
    );

    assign id_bubble = hazard_stall | stall | ~id_valid;

    // flush beats any hold so a taken branch never leaves a stale word behind
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_instruction <= NOP_INSTR;
            id_pc_plus4    <= '0;
            id_valid       <= 1'b0;
        end else if (flush) begin
            id_instruction <= NOP_INSTR;
            id_pc_plus4    <= '0;
            id_valid       <= 1'b0;
        end else if (!(stall || hazard_stall)) begin
            id_instruction <= if_instruction;
            id_pc_plus4    <= if_pc_plus4;
            id_valid       <= if_valid;
        end
    end
endmodule

// File: tb/tb_if_id_register.sv
// tb_if_id_register: randomized scoreboard bench for the IF/ID register
module tb_if_id_register;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_pc_plus4 = '0, if_instruction = '0;
    logic        if_valid = 1'b0, stall = 1'b0, flush = 1'b0, ex_mem_read = 1'b0;
    logic [4:0]  ex_rt = '0;
    logic [31:0] id_pc_plus4, id_instruction;
    logic        id_valid, hazard_stall, id_bubble;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] immediate;
    logic [25:0] jump_index;

    if_id_register dut (
        .clock(clock), .reset(reset), .if_pc_plus4(if_pc_plus4), .if_instruction(if_instruction),
        .if_valid(if_valid), .stall(stall), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_pc_plus4(id_pc_plus4), .id_instruction(id_instruction), .id_valid(id_valid),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .immediate(immediate), .jump_index(jump_index), .hazard_stall(hazard_stall), .id_bubble(id_bubble)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        hz;
        logic        bub;
    } rec_t;
    rec_t q[$];

    int n_chk = 0, n_fail = 0;
    logic [31:0] m_instr = '0, m_pc = '0;
    logic        m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_hz(input logic [31:0] ins, input logic v, input logic mr, input logic [4:0] er);
        int op, s, t;
        logic reads_rt;
        op = int'(ins >> 26);
        s  = int'((ins >> 21) & 32'd31);
        t  = int'((ins >> 16) & 32'd31);
        reads_rt = (op == 0) || (op == 4) || (op == 5) || (op == 43);
        return v && mr && er != 0 && (int'(er) == s || (reads_rt && int'(er) == t));
    endfunction

    function automatic rec_t snapshot();
        rec_t r;
        r.instr = m_instr;
        r.pc    = m_pc;
        r.valid = m_valid;
        r.hz    = model_hz(m_instr, m_valid, ex_mem_read, ex_rt);
        r.bub   = r.hz || stall || !m_valid;
        return r;
    endfunction

    // apply the edge that just happened to the model, then drive the next cycle's inputs
    task automatic cyc(input logic s, input logic f, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic mr, input logic [4:0] er);
        logic hz;
        @(posedge clock);
        #1;
        hz = model_hz(m_instr, m_valid, ex_mem_read, ex_rt);
        if (reset || flush) begin
            m_instr = '0; m_pc = '0; m_valid = 1'b0;
        end else if (!(stall || hz)) begin
            m_instr = if_instruction; m_pc = if_pc_plus4; m_valid = if_valid;
        end
        reset = 1'b0;
        stall = s; flush = f; if_valid = v; if_instruction = ins; if_pc_plus4 = pc;
        ex_mem_read = mr; ex_rt = er;
        q.push_back(snapshot());
    endtask

    initial begin
        rec_t r;
        forever begin
            @(negedge clock);
            if (q.size() != 0) begin
                r = q.pop_front();
                chk("id_instruction", id_instruction, r.instr);
                chk("id_pc_plus4", id_pc_plus4, r.pc);
                chk("id_valid", 32'(id_valid), 32'(r.valid));
                chk("opcode", 32'(opcode), r.instr >> 26);
                chk("rs", 32'(rs), (r.instr >> 21) & 32'd31);
                chk("rt", 32'(rt), (r.instr >> 16) & 32'd31);
                chk("rd", 32'(rd), (r.instr >> 11) & 32'd31);
                chk("shamt", 32'(shamt), (r.instr >> 6) & 32'd31);
                chk("funct", 32'(funct), r.instr & 32'd63);
                chk("immediate", 32'(immediate), r.instr & 32'hFFFF);
                chk("jump_index", 32'(jump_index), r.instr & 32'h03FF_FFFF);
                chk("hazard_stall", 32'(hazard_stall), 32'(r.hz));
                chk("id_bubble", 32'(id_bubble), 32'(r.bub));
            end
        end
    end

    initial begin
        logic [5:0] ops [7] = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08, 6'h0D};
        logic [31:0] ins;
        @(posedge clock);
        #1;
        chk("reset id_instruction", id_instruction, 32'h0);
        chk("reset hazard_stall", 32'(hazard_stall), 32'h0);
        cyc(0, 0, 1, 32'h2128_FFFC, 32'h10, 1, 5'd8);
        cyc(0, 0, 1, 32'h0022_1820, 32'h14, 1, 5'd8);
        #1;
        chk("load opcode", 32'(opcode), 32'h08);
        chk("load rs", 32'(rs), 32'd9);
        chk("load rt", 32'(rt), 32'd8);
        chk("load immediate", 32'(immediate), 32'hFFFC);
        chk("load pc", id_pc_plus4, 32'h10);
        chk("addi rt dest no hazard", 32'(hazard_stall), 32'h0);
        cyc(0, 0, 1, 32'h8C22_0004, 32'h18, 1, 5'd2);
        #1;
        chk("load-use hazard", 32'(hazard_stall), 32'h1);
        chk("load-use bubble", 32'(id_bubble), 32'h1);
        cyc(0, 0, 1, 32'h8C22_0004, 32'h18, 0, 5'd2);
        #1;
        chk("hazard hold", id_instruction, 32'h0022_1820);
        cyc(0, 0, 1, 32'h8C22_0004, 32'h18, 1, 5'd0);
        #1;
        chk("after hazard load", id_instruction, 32'h8C22_0004);
        chk("ex_rt zero no hazard", 32'(hazard_stall), 32'h0);
        cyc(1, 1, 1, 32'h1234_5678, 32'h1C, 1, 5'd1);
        #1;
        chk("hazard before flush", 32'(hazard_stall), 32'h1);
        cyc(0, 0, 1, 32'h0000_0FFF, 32'h20, 0, 5'd0);
        #1;
        chk("flush id_instruction", id_instruction, 32'h0);
        chk("flush id_valid", 32'(id_valid), 32'h0);
        cyc(1, 0, 1, 32'h1111_1111, 32'h24, 0, 5'd0);
        cyc(1, 0, 1, 32'h2222_2222, 32'h28, 0, 5'd0);
        cyc(1, 0, 1, 32'h3333_3333, 32'h2C, 0, 5'd0);
        cyc(0, 0, 1, 32'h4444_4444, 32'h30, 0, 5'd0);
        #1;
        chk("stall hold", id_instruction, 32'h0000_0FFF);
        cyc(0, 0, 1, 32'h8C22_0004, 32'h34, 0, 5'd0);
        #1;
        chk("stall release load", id_instruction, 32'h4444_4444);
        cyc(0, 0, 0, 32'h0, 32'h38, 0, 5'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset id_instruction", id_instruction, 32'h0);
        chk("async reset id_valid", 32'(id_valid), 32'h0);
        chk("async reset immediate", 32'(immediate), 32'h0);
        chk("async reset pc", id_pc_plus4, 32'h0);
        m_instr = '0; m_pc = '0; m_valid = 1'b0;
        q.delete();
        q.push_back(snapshot());
        for (int i = 0; i < 400; i++) begin
            ins = {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            cyc($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
                ins, $urandom, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)));
        end
        repeat (2) @(posedge clock);
        #1;
        chk("scoreboard drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
